ahb_sram_responder: RTL and testbench
=====================================

// Module: ahb_sram_responder
// PURPOSE
//  AHB-lite responder on one slave port of ahb_switch; consumes S_* request signals, returns S_RDATA/S_RESP/S_READY.
//  Backs a byte-enabled on-chip SRAM (default 16 KB) with programmable wait states and range checking.
//  Pipelined: captures address phase, completes in data phase; write-to-read forwarding covers back-to-back hazards.
// PARAMETERS
//  AW           12   word-address bits; depth = 2**AW 32-bit words
//  WAIT_STATES  0    extra data-phase cycles (S_READY low) per NONSEQ/SEQ transfer, 0..15
//  LIMIT_WORDS  2**AW  words mapped; word offset >= LIMIT_WORDS gives ERROR
// PORTS
//  HCLOCK         in   1   clock, rising edge
//  HRESET         in   1   asynchronous, active-high reset
//  S_ADDRESS      in   32  byte address; bits [27:2] form word offset
//  S_CHIP_SELECT  in   1   port granted by switch
//  S_BYTE_ENABLE  in   4   byte lanes of address-phase transfer
//  S_WRITE        in   1   1 = write
//  S_WDATA        in   32  write data, valid in data phase
//  S_TRANS        in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  S_RDATA        out  32  read data, valid when S_READY=1 in read data phase
//  S_RESP         out  2   00 OKAY, 01 ERROR
//  S_READY        out  1   data-phase completion
// BEHAVIOUR
//  Reset: S_READY=1, S_RESP=00, S_RDATA=0, FSM=IDLE, wait counter 0, pending write cleared.
//  Capture: at rising edge with S_READY=1 && S_CHIP_SELECT && S_TRANS[1]; latch addr, be, write; else data phase is OKAY zero-wait, no access (IDLE/BUSY/unselected).
//  FSM: IDLE -> WAIT (WAIT_STATES>0) or DATA; WAIT counts WAIT_STATES cycles, S_READY=0; DATA drives S_READY=1, S_RESP=00.
//   Out-of-range capture -> ERR1 (S_READY=0, S_RESP=01) -> ERR2 (S_READY=1, S_RESP=01); no memory access; wait states skipped.
//   DATA/ERR2 with new capture at same edge -> next transfer's WAIT/DATA/ERR1 (back-to-back, no bubble); else IDLE.
//  Read: RAM read issued at capture edge from S_ADDRESS word offset; zero-wait read data at S_RDATA in next cycle.
//   With WAIT_STATES>0, S_RDATA held stable from first data-phase cycle to completion.
//   S_RDATA = 0 outside completing read data phase.
//  Write: S_WDATA sampled at completing data-phase edge (S_READY=1), written per latched byte enables; be=0000 is OKAY no-op.
//  Hazard: read captured on the edge a write completes to same word -> S_RDATA uses merged bytes (new where be set, RAM old elsewhere).
//  Addressing: S_ADDRESS[31:28] ignored (switch decodes); [1:0] ignored, lanes from S_BYTE_ENABLE.
//  S_CHIP_SELECT low during WAIT: transfer still completes (switch holds grant until ready); inputs ignored except S_WDATA.
//  Reset mid-transfer: outputs to reset values in same cycle; pending write discarded, RAM contents retained.
// STRUCTURE
//  Package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR localparams, typedef enum {IDLE,WAIT,DATA,ERR1,ERR2} rsp_state_t.
//  Sub-module ahb_sram_array: 1W1R synchronous RAM, 2**AW x 32, per-byte write enable, read-old-data on same-address collision.
//  Top: capture regs, FSM, 4-bit wait counter, forward-merge mux, output regs.
// TESTING
//  Reset then write 0x0000_0010 <- 0xDEADBEEF be=1111, read back -> S_RDATA=0xDEADBEEF, S_RESP=00, zero wait.
//  Back-to-back write 0x10 be=0011 data 0x0000_1234 then read 0x10 -> 0xDEAD1234 via forward path.
//  WAIT_STATES=3 read -> S_READY low exactly 3 cycles, then 1 with data; S_RDATA stable throughout.
//  Addr word offset LIMIT_WORDS (e.g. 0x0000_4000, AW=12) -> ERR1/ERR2: READY 0 then 1, RESP=01 both; RAM unchanged.
//  IDLE/BUSY cycles between NONSEQ/SEQ burst of 4 -> OKAY zero-wait on IDLE/BUSY, burst words correct.
//  Assert HRESET during WAIT of a write -> outputs reset next sample, target word unchanged on later read.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-lite transfer/response encodings, responder FSM states and a byte-merge helper.
// Latency: none (shared definitions only).
// Backpressure: none (shared definitions only).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } rsp_state_t;

    // Take bytes of new_word where be is set, bytes of old_word elsewhere.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// 1W1R synchronous SRAM, 2**AW x 32 bits, per-byte write enables, read-old-data on collision.
// Latency: read data registered one cycle after rd_en; writes land at the enabled edge.
// Backpressure: none; accepts a read and a write every cycle.
module ahb_sram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [2**AW];

    // Byte-lane write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered read; holds its value until the next read so wait-state data stays stable.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-lite responder backing an on-chip SRAM with programmable wait states and range checking.
// Latency: zero-wait data phase after address capture plus WAIT_STATES; out-of-range costs one ERROR wait.
// Backpressure: S_READY low during WAIT and ERR1; address phases are captured only while S_READY is high.
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 0,
    parameter int LIMIT_WORDS = 2**AW
) (
    input  logic        HCLOCK,
    input  logic        HRESET,
    input  logic [31:0] S_ADDRESS,
    input  logic        S_CHIP_SELECT,
    input  logic [3:0]  S_BYTE_ENABLE,
    input  logic        S_WRITE,
    input  logic [31:0] S_WDATA,
    input  logic [1:0]  S_TRANS,
    output logic [31:0] S_RDATA,
    output logic [1:0]  S_RESP,
    output logic        S_READY
);

    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    rsp_state_t    state, state_nxt, cap_state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] word_addr;
    logic [3:0]    lat_be;
    logic          lat_write;
    logic          fwd_hit;
    logic [3:0]    fwd_be;
    logic [31:0]   fwd_data;
    logic [31:0]   ram_rdata;
    logic [31:0]   rd_word;

    // Top nibble is decoded by the switch and lanes come from S_BYTE_ENABLE.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_ADDRESS[31:28], S_ADDRESS[1:0]};

    logic [25:0] req_offset;
    logic        req_in_range, is_xfer, capture, wr_fire, rd_issue;

    assign req_offset   = S_ADDRESS[27:2];
    assign req_in_range = ({6'd0, req_offset} < 32'(LIMIT_WORDS));
    assign is_xfer      = (S_TRANS == HTRANS_NONSEQ) || (S_TRANS == HTRANS_SEQ);
    assign capture      = S_READY && S_CHIP_SELECT && is_xfer;
    assign wr_fire      = (state == DATA) && lat_write;
    assign rd_issue     = capture && req_in_range && !S_WRITE;
    assign cap_state    = !req_in_range ? ERR1 : ((WAIT_STATES > 0) ? WAIT : DATA);

    ahb_sram_array #(.AW(AW)) u_ram (
        .clk     (HCLOCK),
        .wr_en   (wr_fire),
        .wr_addr (word_addr),
        .wr_be   (lat_be),
        .wr_data (S_WDATA),
        .rd_en   (rd_issue),
        .rd_addr (req_offset[AW-1:0]),
        .rd_data (ram_rdata)
    );

    // State register.
    always_ff @(posedge HCLOCK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: completing phases chain straight into a newly captured transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DATA, ERR2: state_nxt = capture ? cap_state : IDLE;
            WAIT:             state_nxt = (wait_cnt == WS_LAST) ? DATA : WAIT;
            ERR1:             state_nxt = ERR2;
            default:          state_nxt = IDLE;
        endcase
    end

    // Wait counter runs only while in WAIT and restarts from zero for every transfer.
    always_ff @(posedge HCLOCK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Address-phase capture plus forwarding snapshot when a read lands on a word being written now.
    always_ff @(posedge HCLOCK or posedge HRESET) begin
        if (HRESET) begin
            word_addr <= '0;
            lat_be    <= '0;
            lat_write <= 1'b0;
            fwd_hit   <= 1'b0;
            fwd_be    <= '0;
            fwd_data  <= '0;
        end else if (capture) begin
            word_addr <= req_offset[AW-1:0];
            lat_be    <= S_BYTE_ENABLE;
            lat_write <= S_WRITE;
            fwd_hit   <= rd_issue && wr_fire && (word_addr == req_offset[AW-1:0]);
            fwd_be    <= lat_be;
            fwd_data  <= S_WDATA;
        end
    end

    assign rd_word = fwd_hit ? merge_bytes(ram_rdata, fwd_data, fwd_be) : ram_rdata;

    // Outputs decode from registered state, so reset forces them immediately.
    always_comb begin
        S_READY = !((state == WAIT) || (state == ERR1));
        S_RESP  = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        S_RDATA = (((state == WAIT) || (state == DATA)) && !lat_write) ? rd_word : 32'd0;
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
`timescale 1ns/1ps
module tb_ahb_sram_responder;
    import ahb_pkg::*;

    localparam int NP = 2;   // port 0: WAIT_STATES=0, port 1: WAIT_STATES=3

    typedef struct {
        logic        is_read;
        logic [1:0]  resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr  [NP];
    logic        sel   [NP];
    logic [3:0]  be    [NP];
    logic        wr    [NP];
    logic [31:0] wdata [NP];
    logic [1:0]  trans [NP];
    logic [31:0] rdata [NP];
    logic [1:0]  resp  [NP];
    logic        rdy   [NP];

    int vectors = 0;
    int miscompares = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic        in_dp [NP] = '{1'b0, 1'b0};
    int          wcnt  [NP] = '{0, 0};
    logic [31:0] held  [NP] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    ahb_sram_responder #(.AW(12), .WAIT_STATES(0)) u_dut0 (
        .HCLOCK(clk), .HRESET(rst), .S_ADDRESS(addr[0]), .S_CHIP_SELECT(sel[0]),
        .S_BYTE_ENABLE(be[0]), .S_WRITE(wr[0]), .S_WDATA(wdata[0]), .S_TRANS(trans[0]),
        .S_RDATA(rdata[0]), .S_RESP(resp[0]), .S_READY(rdy[0])
    );

    ahb_sram_responder #(.AW(12), .WAIT_STATES(3)) u_dut3 (
        .HCLOCK(clk), .HRESET(rst), .S_ADDRESS(addr[1]), .S_CHIP_SELECT(sel[1]),
        .S_BYTE_ENABLE(be[1]), .S_WRITE(wr[1]), .S_WDATA(wdata[1]), .S_TRANS(trans[1]),
        .S_RDATA(rdata[1]), .S_RESP(resp[1]), .S_READY(rdy[1])
    );

    task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s port%0d: got 0x%08h, expected 0x%08h at %0t", name, p, act, req, $time);
        end
    endtask

    function automatic void push(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic bit pop(input int p, output exp_t e);
        e = '{1'b0, 2'b00, 32'd0, 0};
        if (p == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic monitor_port(input int p);
        exp_t e;
        if (rst) begin
            check("rst_ready", p, {31'd0, rdy[p]}, 32'd1);
            check("rst_resp",  p, {30'd0, resp[p]}, 32'd0);
            check("rst_rdata", p, rdata[p], 32'd0);
            if (in_dp[p]) void'(pop(p, e));
            in_dp[p] = 1'b0;
            wcnt[p]  = 0;
            return;
        end
        if (in_dp[p]) begin
            if (!rdy[p]) begin
                if (wcnt[p] == 0) held[p] = rdata[p];
                else              check("rdata_stable", p, rdata[p], held[p]);
                wcnt[p]++;
                if (wcnt[p] > 20) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ready_timeout port%0d: waited %0d cycles, expected completion", p, wcnt[p]);
                    void'(pop(p, e));
                    in_dp[p] = 1'b0;
                    wcnt[p]  = 0;
                end
            end else begin
                if (!pop(p, e)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_completion port%0d: got completion, expected none", p);
                end else begin
                    check("resp",        p, {30'd0, resp[p]}, {30'd0, e.resp});
                    check("wait_cycles", p, 32'(wcnt[p]), 32'(e.waits));
                    check("rdata",       p, rdata[p], e.is_read ? e.data : 32'd0);
                    if (e.is_read && wcnt[p] > 0) check("rdata_held", p, rdata[p], held[p]);
                end
                in_dp[p] = 1'b0;
                wcnt[p]  = 0;
            end
        end else begin
            check("idle_ready_resp", p, {29'd0, rdy[p], resp[p]}, 32'h4);
            check("idle_rdata",      p, rdata[p], 32'd0);
        end
        if (rdy[p] && sel[p] && trans[p][1]) in_dp[p] = 1'b1;
    endtask

    // Monitor: outputs and next-edge inputs are both stable at the falling edge.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) monitor_port(p);
    end

    // Issue one address phase, wait for it to be taken, then present its write data.
    task automatic xfer(input int p, input logic [1:0] tr, input logic s, input logic w,
                        input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd,
                        input exp_t e);
        int n;
        addr[p] = a; trans[p] = tr; sel[p] = s; wr[p] = w; be[p] = b;
        if (s && tr[1]) push(p, e);
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy[p]) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 50) begin
                $display("FAIL accept_timeout port%0d: no ready within %0d cycles", p, n);
                $fatal(1, "address phase never accepted");
            end
        end
        wdata[p] = w ? wd : 32'h0BAD_0BAD;
        addr[p] = 32'd0; trans[p] = HTRANS_IDLE; sel[p] = 1'b0; wr[p] = 1'b0; be[p] = 4'h0;
    endtask

    task automatic wr_t(input int p, input logic [1:0] tr, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [1:0] r, input int waits);
        xfer(p, tr, 1'b1, 1'b1, a, b, d, '{1'b0, r, 32'd0, waits});
    endtask

    task automatic rd_t(input int p, input logic [1:0] tr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] r, input int waits);
        xfer(p, tr, 1'b1, 1'b0, a, 4'hF, 32'd0, '{1'b1, r, d, waits});
    endtask

    task automatic idle_t(input int p, input logic [1:0] tr, input int n);
        for (int i = 0; i < n; i++) xfer(p, tr, 1'b1, 1'b0, 32'd0, 4'h0, 32'd0, '{1'b0, 2'b00, 32'd0, 0});
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            addr[p] = 32'd0; sel[p] = 1'b0; be[p] = 4'h0; wr[p] = 1'b0;
            wdata[p] = 32'd0; trans[p] = HTRANS_IDLE;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait port: basic write/read, forwarding, no-op writes
        wr_t(0, HTRANS_NONSEQ, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0010, 32'hDEAD_BEEF, HRESP_OKAY, 0);
        wr_t(0, HTRANS_NONSEQ, 32'h0000_0010, 4'h3, 32'h0000_1234, HRESP_OKAY, 0);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0010, 32'hDEAD_1234, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0010, 32'hDEAD_1234, HRESP_OKAY, 0);
        wr_t(0, HTRANS_NONSEQ, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, HRESP_OKAY, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0000_0000, '{1'b0, 2'b00, 32'd0, 0});
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0010, 32'hDEAD_1234, HRESP_OKAY, 0);

        // Range limit: offset 0x1000 aliases word 0 in the array but must not touch it
        wr_t(0, HTRANS_NONSEQ, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, HRESP_OKAY, 0);
        wr_t(0, HTRANS_NONSEQ, 32'h0000_4000, 4'hF, 32'h1111_1111, HRESP_ERROR, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_4000, 32'h0000_0000, HRESP_ERROR, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0000, 32'hA5A5_A5A5, HRESP_OKAY, 0);
        wr_t(0, HTRANS_NONSEQ, 32'h0000_3FFC, 4'hF, 32'h0BAD_F00D, HRESP_OKAY, 0);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_3FFC, 32'h0BAD_F00D, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_3FFC, 32'h0BAD_F00D, HRESP_OKAY, 0);

        // Ignored address bits
        wr_t(0, HTRANS_NONSEQ, 32'hF000_0020, 4'hF, 32'h5555_AAAA, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0022, 32'h5555_AAAA, HRESP_OKAY, 0);

        // Four-beat bursts with BUSY/IDLE gaps
        wr_t(0, HTRANS_NONSEQ, 32'h0000_0100, 4'hF, 32'h0101_0101, HRESP_OKAY, 0);
        idle_t(0, HTRANS_BUSY, 1);
        wr_t(0, HTRANS_SEQ,    32'h0000_0104, 4'hF, 32'h0202_0202, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        wr_t(0, HTRANS_SEQ,    32'h0000_0108, 4'hF, 32'h0303_0303, HRESP_OKAY, 0);
        wr_t(0, HTRANS_SEQ,    32'h0000_010C, 4'hF, 32'h0404_0404, HRESP_OKAY, 0);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0100, 32'h0101_0101, HRESP_OKAY, 0);
        rd_t(0, HTRANS_SEQ,    32'h0000_0104, 32'h0202_0202, HRESP_OKAY, 0);
        idle_t(0, HTRANS_BUSY, 2);
        rd_t(0, HTRANS_SEQ,    32'h0000_0108, 32'h0303_0303, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);
        rd_t(0, HTRANS_SEQ,    32'h0000_010C, 32'h0404_0404, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 2);

        // Three-wait-state port
        wr_t(1, HTRANS_NONSEQ, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, HRESP_OKAY, 3);
        idle_t(1, HTRANS_IDLE, 1);
        rd_t(1, HTRANS_NONSEQ, 32'h0000_0040, 32'hCAFE_F00D, HRESP_OKAY, 3);
        wr_t(1, HTRANS_NONSEQ, 32'h0000_0040, 4'hC, 32'h1234_0000, HRESP_OKAY, 3);
        rd_t(1, HTRANS_NONSEQ, 32'h0000_0040, 32'h1234_F00D, HRESP_OKAY, 3);
        rd_t(1, HTRANS_NONSEQ, 32'h0000_4000, 32'h0000_0000, HRESP_ERROR, 1);
        idle_t(1, HTRANS_IDLE, 2);

        // Reset in the middle of a write's wait states
        wr_t(1, HTRANS_NONSEQ, 32'h0000_0040, 4'hF, 32'hFFFF_FFFF, HRESP_OKAY, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_t(1, HTRANS_NONSEQ, 32'h0000_0040, 32'h1234_F00D, HRESP_OKAY, 3);
        rd_t(0, HTRANS_NONSEQ, 32'h0000_0010, 32'hDEAD_1234, HRESP_OKAY, 0);
        idle_t(0, HTRANS_IDLE, 1);

        for (int i = 0; i < 30 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("queue_drain", 0, 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
